// File: rtl/sensor_csr_sequencer_if.sv
// sensor_csr_sequencer_if: host-side and csr-side Avalon-MM signals of the CSR sequencer.
interface sensor_csr_sequencer_if;
    logic [2:0]  host_address;
    logic        host_write;
    logic        host_read;
    logic [31:0] host_writedata;
    logic [3:0]  host_byteenable;
    logic [31:0] host_readdata;
    logic        host_readdatavalid;
    logic        host_waitrequest;
    logic [2:0]  csr_address;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [3:0]  csr_byteenable;
    logic [31:0] csr_readdata;

    modport slave (
        input  host_address, host_write, host_read, host_writedata, host_byteenable, csr_readdata,
        output host_readdata, host_readdatavalid, host_waitrequest,
        output csr_address, csr_write, csr_read, csr_writedata, csr_byteenable
    );

    modport master (
        output host_address, host_write, host_read, host_writedata, host_byteenable, csr_readdata,
        input  host_readdata, host_readdatavalid, host_waitrequest,
        input  csr_address, csr_write, csr_read, csr_writedata, csr_byteenable
    );
endinterface

// File: rtl/sensor_csr_sequencer.sv
// sensor_csr_sequencer: writes a boot table to the sensor_algo CSR slave, then forwards host accesses.
// Define CSR_SEQ_VERIFY_EN to read back every boot write and flag mismatches on boot_error.
module sensor_csr_sequencer #(
    parameter logic [2:0]  ENTRY_ADDR0 = 3'd2,
    parameter logic [2:0]  ENTRY_ADDR1 = 3'd1,
    parameter logic [2:0]  ENTRY_ADDR2 = 3'd0,
    parameter logic [2:0]  ENTRY_ADDR3 = 3'd3,
    parameter logic [31:0] ENTRY_DATA0 = 32'hAAAA0032,
    parameter logic [31:0] ENTRY_DATA1 = 32'h01200004,
    parameter logic [31:0] ENTRY_DATA2 = 32'h00060001,
    parameter logic [31:0] ENTRY_DATA3 = 32'h20040032,
    parameter int          GAP_CYCLES  = 1
) (
    input  logic clk_clk,
    input  logic rst_reset,
    input  logic boot_start,
    output logic boot_busy,
    output logic boot_done,
    output logic boot_error,
    sensor_csr_sequencer_if.slave bus
);
    localparam logic [2:0]  ENT_ADDR [4] = '{ENTRY_ADDR0, ENTRY_ADDR1, ENTRY_ADDR2, ENTRY_ADDR3};
    localparam logic [31:0] ENT_DATA [4] = '{ENTRY_DATA0, ENTRY_DATA1, ENTRY_DATA2, ENTRY_DATA3};
    localparam bit          GAP_EN   = GAP_CYCLES != 0;
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
`ifdef CSR_SEQ_VERIFY_EN
        RD,
        CHK,
`endif
        RUN
    } state_t;

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [3:0]  gap_cnt, gap_cnt_n;
    logic        leave;
    logic        rd_pend;
    logic        chk_pend;
    logic        write_n, read_n;
    logic [2:0]  addr_n;
    logic [31:0] data_n;
    logic [3:0]  be_n;

    assign boot_done = state == RUN;
    assign boot_busy = !boot_done;
    assign bus.host_waitrequest = !boot_done;
    assign bus.host_readdatavalid = rd_pend && !chk_pend;
    assign bus.host_readdata = bus.host_readdatavalid ? bus.csr_readdata : '0;

    // leave marks the end of one table entry; it either advances to the next entry or finishes
    always_comb begin
        state_n = state;
        idx_n = idx;
        gap_cnt_n = '0;
        leave = 1'b0;
        case (state)
            IDLE: state_n = WR;
            WR: begin
`ifdef CSR_SEQ_VERIFY_EN
                state_n = RD;
`else
                state_n = GAP_EN ? GAP : state;
                leave = !GAP_EN;
`endif
            end
`ifdef CSR_SEQ_VERIFY_EN
            RD: state_n = CHK;
            CHK: begin
                state_n = GAP_EN ? GAP : state;
                leave = !GAP_EN;
            end
`endif
            GAP: begin
                gap_cnt_n = gap_cnt + 4'd1;
                leave = gap_cnt == GAP_LAST;
            end
            RUN: if (boot_start) begin
                state_n = WR;
                idx_n = '0;
            end
            default: state_n = IDLE;
        endcase
        if (leave) begin
            state_n = (idx == 2'd3) ? RUN : WR;
            idx_n = idx + 2'd1;
        end
    end

    // csr_* are registered from the current state, so host requests reach the slave one cycle late
    always_comb begin
        write_n = 1'b0;
        read_n = 1'b0;
        addr_n = bus.csr_address;
        data_n = bus.csr_writedata;
        be_n = bus.csr_byteenable;
        if (state == RUN) begin
            write_n = bus.host_write;
            read_n = bus.host_read && !bus.host_write;
            addr_n = bus.host_address;
            data_n = bus.host_writedata;
            be_n = bus.host_byteenable;
        end else if (state == WR) begin
            write_n = 1'b1;
            addr_n = ENT_ADDR[idx];
            data_n = ENT_DATA[idx];
            be_n = 4'hF;
        end
`ifdef CSR_SEQ_VERIFY_EN
        else if (state == RD) begin
            read_n = 1'b1;
            addr_n = ENT_ADDR[idx];
        end
`endif
    end

    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            state <= IDLE;
            idx <= '0;
            gap_cnt <= '0;
            rd_pend <= 1'b0;
            bus.csr_write <= 1'b0;
            bus.csr_read <= 1'b0;
            bus.csr_address <= '0;
            bus.csr_writedata <= '0;
            bus.csr_byteenable <= 4'hF;
        end else begin
            state <= state_n;
            idx <= idx_n;
            gap_cnt <= gap_cnt_n;
            rd_pend <= bus.csr_read;
            bus.csr_write <= write_n;
            bus.csr_read <= read_n;
            bus.csr_address <= addr_n;
            bus.csr_writedata <= data_n;
            bus.csr_byteenable <= be_n;
        end
    end

`ifdef CSR_SEQ_VERIFY_EN
    logic        boot_rd;
    logic        err;
    logic [31:0] exp_data;

    assign boot_error = err;

    // boot readback data arrives two cycles after RD; chk_pend marks that cycle and hides it from the host
    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            boot_rd <= 1'b0;
            chk_pend <= 1'b0;
            exp_data <= '0;
            err <= 1'b0;
        end else begin
            boot_rd <= state == RD;
            chk_pend <= boot_rd;
            if (state == RD)
                exp_data <= ENT_DATA[idx];
            if (chk_pend && bus.csr_readdata != exp_data)
                err <= 1'b1;
        end
    end
`else
    assign chk_pend = 1'b0;
    assign boot_error = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_csr_sequencer.sv
// tb_sensor_csr_sequencer: scoreboard bench for the boot table, host passthrough, reboot and reset restart.
module tb_sensor_csr_sequencer;
`ifdef CSR_SEQ_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int P = VFY ? 4 : 2;
    localparam int BL = 1 + 4 * P;

    typedef struct {
        bit          rd;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          at;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          at;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boot_start = 1'b0;
    logic boot_busy, boot_done, boot_error;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t0, t1, acc;
    logic [31:0] rd_tbl [8];
    logic [2:0]  ent_addr [4] = '{3'd2, 3'd1, 3'd0, 3'd3};
    logic [31:0] ent_data [4] = '{32'hAAAA0032, 32'h01200004, 32'h00060001, 32'h20040032};
    txn_t wq[$];
    rsp_t rq[$];

    sensor_csr_sequencer_if bus();

    sensor_csr_sequencer dut (
        .clk_clk(clk),
        .rst_reset(rst),
        .boot_start(boot_start),
        .boot_busy(boot_busy),
        .boot_done(boot_done),
        .boot_error(boot_error),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // slave with read latency 1; idle value is distinct so ungated readdata shows up
    always @(posedge clk) bus.csr_readdata <= bus.csr_read ? rd_tbl[bus.csr_address] : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic push_boot(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            wq.push_back('{1'b0, ent_addr[k], ent_data[k], 4'hF, base + 2 + k * P});
            if (VFY && (k < n - 1 || n == 4))
                wq.push_back('{1'b1, ent_addr[k], 32'h0, 4'h0, base + 3 + k * P});
        end
    endtask

    task automatic wait_done(input int exp_cyc);
        for (int n = 0; n < 200 && boot_done !== 1'b1; n++) @(negedge clk);
        chk("boot_done_cycle", 64'(cyc), 64'(exp_cyc));
        chk("waitreq_run", 64'(bus.host_waitrequest), 64'd0);
        chk("boot_busy_run", 64'(boot_busy), 64'd0);
    endtask

    task automatic host_req(input bit w, input bit r, input logic [2:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int acc_cyc);
        bus.host_write = w;
        bus.host_read = r;
        bus.host_address = a;
        bus.host_writedata = d;
        bus.host_byteenable = be;
        for (int n = 0; n < 200 && bus.host_waitrequest !== 1'b0; n++) @(negedge clk);
        if (bus.host_waitrequest !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL host_accept_timeout got=%b exp=0", bus.host_waitrequest);
        end
        acc_cyc = cyc + 1;
        if (w) wq.push_back('{1'b0, a, d, be, acc_cyc});
        else if (r) wq.push_back('{1'b1, a, 32'h0, 4'h0, acc_cyc});
        @(negedge clk);
        bus.host_write = 1'b0;
        bus.host_read = 1'b0;
    endtask

    always @(negedge clk) begin
        txn_t e;
        rsp_t r;
        if (bus.csr_write === 1'b1 || bus.csr_read === 1'b1) begin
            if (wq.size() == 0) begin
                chk("csr_unexpected", 64'({bus.csr_write, bus.csr_read}), 64'd0);
            end else begin
                e = wq.pop_front();
                chk("csr_txn",
                    64'({bus.csr_read, bus.csr_write, bus.csr_address,
                         bus.csr_write ? bus.csr_writedata : 32'h0, bus.csr_write ? bus.csr_byteenable : 4'h0}),
                    64'({e.rd, !e.rd, e.addr, e.rd ? 32'h0 : e.data, e.rd ? 4'h0 : e.be}));
                chk("csr_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (bus.host_readdatavalid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("rdv_unexpected", 64'(bus.host_readdatavalid), 64'd0);
            end else begin
                r = rq.pop_front();
                chk("rd_data", 64'(bus.host_readdata), 64'(r.data));
                chk("rd_cycle", 64'(cyc), 64'(r.at));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rd_tbl[i] = 32'hDEAD0000 | 32'(i);
        for (int k = 0; k < 4; k++) rd_tbl[ent_addr[k]] = ent_data[k];
        if (VFY) rd_tbl[1] = 32'h0;
        bus.host_write = 1'b0;
        bus.host_read = 1'b0;
        bus.host_address = '0;
        bus.host_writedata = '0;
        bus.host_byteenable = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_csr_write", 64'(bus.csr_write), 64'd0);
        chk("rst_csr_read", 64'(bus.csr_read), 64'd0);
        chk("rst_csr_address", 64'(bus.csr_address), 64'd0);
        chk("rst_csr_writedata", 64'(bus.csr_writedata), 64'd0);
        chk("rst_csr_byteenable", 64'(bus.csr_byteenable), 64'hF);
        chk("rst_readdatavalid", 64'(bus.host_readdatavalid), 64'd0);
        chk("rst_readdata", 64'(bus.host_readdata), 64'd0);
        chk("rst_waitrequest", 64'(bus.host_waitrequest), 64'd1);
        chk("rst_boot_busy", 64'(boot_busy), 64'd1);
        chk("rst_boot_done", 64'(boot_done), 64'd0);
        chk("rst_boot_error", 64'(boot_error), 64'd0);

        // boot from reset with a host write held off by waitrequest
        t0 = cyc;
        rst = 1'b0;
        push_boot(t0, 4);
        bus.host_write = 1'b1;
        bus.host_address = 3'd4;
        bus.host_writedata = 32'h12345678;
        bus.host_byteenable = 4'hF;
        wq.push_back('{1'b0, 3'd4, 32'h12345678, 4'hF, t0 + BL + 1});
        wait_done(t0 + BL);
        chk("boot_error_first", 64'(boot_error), 64'(VFY));
        @(negedge clk);
        bus.host_write = 1'b0;

        // host read latency and back-to-back passthrough
        rd_tbl[3] = 32'hCAFE0001;
        rd_tbl[5] = 32'hCAFE0005;
        rd_tbl[7] = 32'hCAFE0007;
        host_req(1'b0, 1'b1, 3'd3, 32'h0, 4'hF, acc);
        rq.push_back('{32'hCAFE0001, acc + 1});
        host_req(1'b0, 1'b1, 3'd5, 32'h0, 4'hF, acc);
        rq.push_back('{32'hCAFE0005, acc + 1});
        host_req(1'b1, 1'b0, 3'd6, 32'hA5A5A5A5, 4'h3, acc);
        host_req(1'b0, 1'b1, 3'd7, 32'h0, 4'hF, acc);
        rq.push_back('{32'hCAFE0007, acc + 1});
        host_req(1'b1, 1'b1, 3'd1, 32'h0000BEEF, 4'hC, acc);
        repeat (3) @(negedge clk);

        // reboot coincident with a host write, with a read still in flight
        host_req(1'b0, 1'b1, 3'd5, 32'h0, 4'hF, acc);
        rq.push_back('{32'hCAFE0005, acc + 1});
        boot_start = 1'b1;
        host_req(1'b1, 1'b0, 3'd2, 32'h00000055, 4'hF, acc);
        boot_start = 1'b0;
        push_boot(acc - 1, 4);
        chk("done_low_rewrite", 64'(boot_done), 64'd0);
        chk("waitreq_rewrite", 64'(bus.host_waitrequest), 64'd1);
        repeat (2) @(negedge clk);
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
        wait_done(acc - 1 + BL);

        // reset right after the second boot write restarts from entry 0
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        t0 = cyc;
        rst = 1'b0;
        push_boot(t0, 2);
        repeat (2 + P) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_clears_error", 64'(boot_error), 64'd0);
        chk("rst_mid_busy", 64'(boot_busy), 64'd1);
        t1 = cyc;
        rst = 1'b0;
        push_boot(t1, 4);
        wait_done(t1 + BL);
        chk("boot_error_final", 64'(boot_error), 64'(VFY));
        repeat (4) @(negedge clk);
        chk("csr_queue_empty", 64'(wq.size()), 64'd0);
        chk("rd_queue_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sensor_csr_sequencer.md
# sensor_csr_sequencer

Boot-time configuration sequencer and CSR arbiter for the sensor_algo subsystem. After reset, or on request, it writes a fixed, parameterised table of register values to the sensor_algo Avalon-MM CSR slave. After that it hands the CSR port to the host master as a registered passthrough. It sits between the host interconnect and the sensor_algo csr port, so the sensor interface always starts from a known configuration without software intervention.

## Interface
- ENTRY_ADDR0..3, default 2, 1, 0, 3: CSR word address of table entry n; entries are written in index order.
- ENTRY_DATA0..3, default 32'hAAAA0032, 32'h01200004, 32'h00060001, 32'h20040032: write data of entry n.
- GAP_CYCLES, default 1, range 0–15: idle cycles inserted after each boot write.
- clk_clk  in  1  single clock; every register in the block uses it.
- rst_reset  in  1  reset, synchronous and active-high.
- boot_start  in  1  single-cycle pulse; re-runs the boot table.
- host_address  in  3  host word address.
- host_write / host_read  in  1  host strobes.
- host_writedata  in  32  host write data.
- host_byteenable  in  4  host byte enables.
- host_readdata  out  32  read data returned to the host.
- host_readdatavalid  out  1  qualifies host_readdata.
- host_waitrequest  out  1  host must hold its request while this is high.
- csr_address  out  3  to the sensor_algo CSR slave.
- csr_write / csr_read  out  1  to the sensor_algo CSR slave.
- csr_writedata  out  32  to the sensor_algo CSR slave.
- csr_byteenable  out  4  to the sensor_algo CSR slave.
- csr_readdata  in  32  from the sensor_algo CSR slave; fixed read latency of 1.
- boot_busy  out  1  high while the table is being written.
- boot_done  out  1  set when the table completes; cleared by reset or boot_start.
- boot_error  out  1  sticky readback mismatch flag; only driven when verify is compiled in.

## Operation
- States:
  - IDLE
  - WR
  - GAP
  - RD (verify only)
  - CHK (verify only)
  - RUN
- Reset → IDLE.
- IDLE → WR on the next cycle, with entry index = 0.
- WR, one cycle:
  - csr_write = 1, csr_byteenable = 4'hF.
  - Address and data come from entry[idx].
- After WR:
  - Verify compiled in → RD.
  - Otherwise → GAP.
- GAP counts GAP_CYCLES cycles; GAP_CYCLES = 0 skips it.
  - Then idx < 3 → idx+1, WR.
  - idx = 3 → RUN, and boot_done is set.
- boot_busy = 1 in every state except RUN.
- In every state except RUN, host_waitrequest = 1 and no host access reaches csr_*.
- RUN, host passthrough:
  - host_waitrequest = 0.
  - host_* are registered onto csr_*, so the slave sees the request 1 cycle after the host issues it.
  - host_readdatavalid pulses 1 cycle after csr_read, with host_readdata = csr_readdata.
- host_write and host_read asserted together: the write wins and the read is dropped.
- boot_start in RUN:
  - A host request presented in the same cycle is accepted and forwarded.
  - Next cycle: state = WR, idx = 0, boot_done = 0.
  - A read already in flight still returns its host_readdatavalid.
- boot_start outside RUN is ignored; a sequence is never restarted mid-table.
- Reset mid-sequence: returns to IDLE and the whole table is rewritten from entry 0.

## Timing
- Reset values:
  - csr_write, csr_read, csr_address, csr_writedata = 0.
  - csr_byteenable = 4'hF.
  - host_readdatavalid = 0, host_readdata = 0, host_waitrequest = 1.
  - boot_busy = 1, boot_done = 0, boot_error = 0.
- First csr_write occurs on the 2nd cycle after rst_reset deasserts.
- Boot length without verify: 1 + 4·(1+GAP_CYCLES) cycles to RUN.
- Host write latency to the slave: 1 cycle.
- Host read latency to host_readdatavalid: 2 cycles.
- The passthrough is fully pipelined: one host request can be issued per cycle.

## Configuration
- CSR_SEQ_VERIFY_EN defined:
  - After each WR: RD asserts csr_read for 1 cycle at the same address.
  - CHK compares csr_readdata with entry[idx] and sets boot_error on mismatch.
  - A mismatch does not stop the sequence.
  - Boot length grows by 2 cycles per entry.
- CSR_SEQ_VERIFY_EN undefined:
  - RD and CHK states are absent.
  - boot_error is tied to 0.
  - No csr_read is issued during boot.

## Test plan
- Default parameters, GAP_CYCLES = 1, release reset:
  - csr writes (2, AAAA0032), (1, 01200004), (0, 00060001), (3, 20040032), 2 cycles apart.
  - boot_done rises at cycle 9 and host_waitrequest falls in the same cycle.
- Host write to address 4 with data 0x12345678 during boot: held by waitrequest, then appears on csr_* 1 cycle after RUN is entered.
- Host read of address 3 in RUN with the slave returning 0xCAFE0001: host_readdatavalid and host_readdata = 0xCAFE0001 exactly 2 cycles after host_read.
- boot_start coincident with a host write in RUN: the host write is forwarded, then the full 4-entry table is rewritten and boot_done is low during rewrite.
- rst_reset asserted after the 2nd boot write: sequence restarts at entry 0 and all 4 writes are repeated.
- Verify build with the slave returning 0 for address 1: boot_error = 1 and stays set, boot_done still asserts, all 4 writes are still issued.
